fast_square_slicer: RTL and testbench
=====================================

FAST_SQUARE_SLICER -- requirements
Module: fast_square_slicer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16: signed I/Q sample width.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: packed output word width, in bits per channel.
REQ-003 SHALL have parameter AVG_SHIFT, default 16: DC-average time constant, 2^AVG_SHIFT samples.
REQ-004 SHALL have parameter HYST, default 0: hysteresis half-band in LSBs, used only under FSQ_HYSTERESIS_EN.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_strobe  in  1  i_in/q_in valid this cycle.
- record  in  1  capture enable (level).
- freq_step  in  1  one-cycle pulse requesting a frame marker.
- i_in, q_in  in  IN_WIDTH  signed samples.
- out_ready  in  1  consumer accepts the held word.
- out_valid  out  1  held word available.
- i_out, q_out  out  OUT_WIDTH  packed slicer bits or marker.
- overflow  out  1  sticky: a completed word was dropped.
- i_dc, q_dc  out  IN_WIDTH  current DC estimates.

Function
REQ-006 SHALL keep per-channel signed accumulators acc of IN_WIDTH+AVG_SHIFT bits; dc = acc[MSB -: IN_WIDTH].
REQ-007 On in_strobe SHALL do acc <= acc + sign-extended (in - dc), with the difference computed in IN_WIDTH+1 bits (no wrap); accumulators update in every state.
REQ-008 Slicer bit SHALL be signed (in > dc) for each sample with in_strobe.
REQ-009 FSM states SHALL be IDLE, MARK and PACK; reset state is IDLE.
REQ-010 IDLE->MARK SHALL occur when record is 1 (rising or held); any state->IDLE when record is 0, discarding the partial word.
REQ-011 In PACK, a freq_step SHALL cause ->MARK, discarding the partial word; freq_step SHALL be ignored in IDLE and MARK.
REQ-012 MARK SHALL load i_out=q_out=1<<(OUT_WIDTH-1) into the holding register as soon as it is free (out_valid=0, or out_valid&&out_ready this cycle), then go to PACK with bit count 0; samples arriving while in MARK SHALL NOT be packed.
REQ-013 In PACK, each strobed sample SHALL shift its slicer bit into the LSB of the per-channel shift register; the OUT_WIDTH-th bit completes a word.
REQ-014 A completed word SHALL appear on i_out/q_out with out_valid=1 the cycle after the completing strobe (latency 1); the count wraps to 0.
REQ-015 The holding register SHALL be one entry; the word SHALL be consumed when out_valid&&out_ready, and out_valid SHALL clear next cycle unless a new word loads the same cycle.
REQ-016 If a word completes while the holder is full and not consumed, the word SHALL be dropped and overflow set; overflow clears only on reset.
REQ-017 If freq_step and a completing strobe occur in the same cycle, freq_step SHALL win and the word SHALL be discarded (no overflow).
REQ-018 Outputs SHALL hold their value while out_valid=1 and out_ready=0.

Reset
REQ-019 Assertion of reset_n=0 SHALL asynchronously clear the accumulators, shift registers, count, i_out, q_out, out_valid and overflow to 0, with the FSM in IDLE.
REQ-020 Reset mid-word or mid-MARK SHALL abandon all pending data; the first post-reset record starts with a marker.

Configuration
REQ-021 Macro FSQ_HYSTERESIS_EN SHALL control hysteresis in the slicer.
- Defined: the bit is 1 when in > dc+HYST, 0 when in < dc-HYST, otherwise the previous bit of that channel; the previous bit is 0 after reset.
- Undefined: REQ-008 applies and HYST is unused.

Verification
REQ-022 Reset, record=1, out_ready=1 -> one marker 16'h8000/16'h8000, then PACK.
REQ-023 Defaults, i_in=+1000 and q_in=-1000 constant, strobe every cycle after reset -> first data word i=16'hFFFF, q=16'h0000; i_dc rises monotonically toward 1000.
REQ-024 freq_step after 7 packed bits -> the partial word is never output, a marker follows, and the next data word has exactly 16 new bits.
REQ-025 out_ready=0 across two word completions -> first word held stable, second dropped, overflow=1 and it stays 1 after out_ready returns.
REQ-026 reset_n pulsed low mid-word, asynchronous to clock -> out_valid=0 and i_dc=0 immediately, without waiting for a clock edge.
REQ-027 FSQ_HYSTERESIS_EN, HYST=50, dc settled at 0, input toggling +/-30 -> the slicer bit holds its previous value and all words are constant.

Source files
------------

// File: rtl/fast_square_slicer.sv
// fast_square_slicer
// Removes a running DC estimate from a signed I/Q sample stream and turns the
// sign of each corrected sample into a slicer bit. Runs of OUT_WIDTH slicer
// bits are packed per channel into words. A marker word starts every capture
// frame. Completed words go into a one-entry holding register with a
// valid/ready handshake.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   in_strobe          i_in/q_in valid this cycle
//   record             capture enable (level); low returns to idle
//   freq_step          one-cycle pulse: abandon the current word, emit a marker
//   i_in, q_in         signed input samples
//   out_ready          consumer accepts the held word
//   out_valid          held word available
//   i_out, q_out       packed slicer bits, or the marker 1<<(OUT_WIDTH-1)
//   overflow           sticky; a completed word was dropped (cleared by reset)
//   i_dc, q_dc         current DC estimates
//
// Build option: define FSQ_HYSTERESIS_EN to give the slicer a +/-HYST dead band.
// Inside the dead band the slicer repeats that channel's previous bit.
module fast_square_slicer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int AVG_SHIFT = 16,
  parameter int HYST      = 0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_strobe,
  input  logic                        record,
  input  logic                        freq_step,
  input  logic signed [IN_WIDTH-1:0]  i_in,
  input  logic signed [IN_WIDTH-1:0]  q_in,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic        [OUT_WIDTH-1:0] i_out,
  output logic        [OUT_WIDTH-1:0] q_out,
  output logic                        overflow,
  output logic signed [IN_WIDTH-1:0]  i_dc,
  output logic signed [IN_WIDTH-1:0]  q_dc
);

  localparam int ACC_W = IN_WIDTH + AVG_SHIFT;
  localparam int CNT_W = $clog2(OUT_WIDTH);
  localparam logic [OUT_WIDTH-1:0] MARKER = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MARK = 2'd1, PACK = 2'd2} state_t;

  state_t                    state_r, state_nx_s;
  logic signed [ACC_W-1:0]   acc_i_r, acc_q_r;
  logic signed [IN_WIDTH:0]  diff_i_s, diff_q_s;
  logic                      bit_i_s, bit_q_s;
  logic [OUT_WIDTH-2:0]      sh_i_r, sh_q_r;
  logic [OUT_WIDTH-1:0]      word_i_s, word_q_s;
  logic [CNT_W-1:0]          cnt_r;
  logic                      holder_free_s, load_mark_s, load_word_s, drop_s, complete_s;
  logic                      pack_stay_s;

  // A negative dead band has no meaning; the check keeps HYST referenced in every build.
  if (HYST < 0) begin : g_hyst_negative
  end

  assign i_dc = acc_i_r[ACC_W-1 -: IN_WIDTH];
  assign q_dc = acc_q_r[ACC_W-1 -: IN_WIDTH];

  // One extra bit on the difference so a full-scale swing never wraps.
  assign diff_i_s = {i_in[IN_WIDTH-1], i_in} - {i_dc[IN_WIDTH-1], i_dc};
  assign diff_q_s = {q_in[IN_WIDTH-1], q_in} - {q_dc[IN_WIDTH-1], q_dc};

`ifdef FSQ_HYSTERESIS_EN
  localparam logic signed [IN_WIDTH+1:0] HB = (IN_WIDTH+2)'(HYST);
  logic signed [IN_WIDTH+1:0] in_x_i_s, in_x_q_s, dc_x_i_s, dc_x_q_s;
  logic prev_i_r, prev_q_r;

  assign in_x_i_s = (IN_WIDTH+2)'(i_in);
  assign in_x_q_s = (IN_WIDTH+2)'(q_in);
  assign dc_x_i_s = (IN_WIDTH+2)'(i_dc);
  assign dc_x_q_s = (IN_WIDTH+2)'(q_dc);

  // Slicer with dead band; inside the band the channel keeps its last decision.
  always_comb begin
    bit_i_s = prev_i_r;
    bit_q_s = prev_q_r;
    if (in_x_i_s > dc_x_i_s + HB) bit_i_s = 1'b1;
    else if (in_x_i_s < dc_x_i_s - HB) bit_i_s = 1'b0;
    else bit_i_s = prev_i_r;
    if (in_x_q_s > dc_x_q_s + HB) bit_q_s = 1'b1;
    else if (in_x_q_s < dc_x_q_s - HB) bit_q_s = 1'b0;
    else bit_q_s = prev_q_r;
  end

  // Last slicer decision per channel, refreshed on every strobed sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_i_r <= 1'b0;
      prev_q_r <= 1'b0;
    end else if (in_strobe) begin
      prev_i_r <= bit_i_s;
      prev_q_r <= bit_q_s;
    end else begin
      prev_i_r <= prev_i_r;
      prev_q_r <= prev_q_r;
    end
  end
`else
  assign bit_i_s = (i_in > i_dc);
  assign bit_q_s = (q_in > q_dc);
`endif

  assign word_i_s = {sh_i_r, bit_i_s};
  assign word_q_s = {sh_q_r, bit_q_s};

  // DC trackers run in every state so the estimate is settled before capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_i_r <= '0;
      acc_q_r <= '0;
    end else if (in_strobe) begin
      acc_i_r <= acc_i_r + {{(AVG_SHIFT-1){diff_i_s[IN_WIDTH]}}, diff_i_s};
      acc_q_r <= acc_q_r + {{(AVG_SHIFT-1){diff_q_s[IN_WIDTH]}}, diff_q_s};
    end else begin
      acc_i_r <= acc_i_r;
      acc_q_r <= acc_q_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_nx_s;
  end

  // Next-state logic; dropping record wins over everything else.
  always_comb begin
    state_nx_s = state_r;
    if (!record) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nx_s = MARK;
        MARK:    state_nx_s = holder_free_s ? PACK : MARK;
        PACK:    state_nx_s = freq_step ? MARK : PACK;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // Control strobes; a completing strobe loses to freq_step and to record low.
  always_comb begin
    holder_free_s = !out_valid || out_ready;
    pack_stay_s   = (state_r == PACK) && record && !freq_step;
    complete_s    = pack_stay_s && in_strobe && (cnt_r == LAST_BIT);
    load_mark_s   = (state_r == MARK) && record && holder_free_s;
    load_word_s   = complete_s && holder_free_s;
    drop_s        = complete_s && !holder_free_s;
  end

  // Bit packing; the partial word is cleared whenever PACK is left or entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_i_r <= '0;
      sh_q_r <= '0;
      cnt_r  <= '0;
    end else if (pack_stay_s) begin
      if (in_strobe) begin
        sh_i_r <= word_i_s[OUT_WIDTH-2:0];
        sh_q_r <= word_q_s[OUT_WIDTH-2:0];
        cnt_r  <= complete_s ? '0 : cnt_r + CNT_W'(1);
      end else begin
        sh_i_r <= sh_i_r;
        sh_q_r <= sh_q_r;
        cnt_r  <= cnt_r;
      end
    end else begin
      sh_i_r <= '0;
      sh_q_r <= '0;
      cnt_r  <= '0;
    end
  end

  // One-entry holding register with a sticky drop flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= overflow | drop_s;
      if (load_mark_s) begin
        i_out     <= MARKER;
        q_out     <= MARKER;
        out_valid <= 1'b1;
      end else if (load_word_s) begin
        i_out     <= word_i_s;
        q_out     <= word_q_s;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_fast_square_slicer.sv
// Randomized self-checking bench for fast_square_slicer. The reference model
// keeps the DC trackers as plain integers. It collects slicer bits in queues
// and treats the output stage as a one-slot mailbox.
module tb_fast_square_slicer;

  localparam int IN_WIDTH  = 16;
  localparam int OUT_WIDTH = 16;
  localparam int AVG_SHIFT = 16;
`ifdef FSQ_HYSTERESIS_EN
  localparam int HYST = 50;
`else
  localparam int HYST = 0;
`endif

  logic clock, reset_n, in_strobe, record, freq_step, out_ready;
  logic signed [IN_WIDTH-1:0] i_in, q_in;
  logic out_valid, overflow;
  logic [OUT_WIDTH-1:0] i_out, q_out;
  logic signed [IN_WIDTH-1:0] i_dc, q_dc;

  fast_square_slicer #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .AVG_SHIFT(AVG_SHIFT), .HYST(HYST)
  ) dut (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .record(record),
    .freq_step(freq_step), .i_in(i_in), .q_in(q_in), .out_ready(out_ready),
    .out_valid(out_valid), .i_out(i_out), .q_out(q_out), .overflow(overflow),
    .i_dc(i_dc), .q_dc(q_dc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  longint m_acc_i, m_acc_q;
  int     m_mode;            // 0 idle, 1 waiting to emit marker, 2 collecting bits
  bit     m_bits_i[$], m_bits_q[$];
  bit     m_valid, m_ov, m_prev_i, m_prev_q;
  longint m_iout, m_qout;

  localparam longint MARK_WORD = 64'd1 << (OUT_WIDTH - 1);

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint pack_bits(input bit qq[$]);
    longint v = 0;
    foreach (qq[k]) v = (v << 1) | longint'(qq[k]);
    return v;
  endfunction

  function automatic bit decide(input longint x, input longint dc, input bit prev);
`ifdef FSQ_HYSTERESIS_EN
    if (x > dc + HYST) return 1'b1;
    else if (x < dc - HYST) return 1'b0;
    else return prev;
`else
    return (x > dc) ^ (prev & 1'b0);
`endif
  endfunction

  task automatic model_reset();
    m_acc_i = 0; m_acc_q = 0; m_mode = 0;
    m_bits_i.delete(); m_bits_q.delete();
    m_valid = 0; m_ov = 0; m_prev_i = 0; m_prev_q = 0;
    m_iout = 0; m_qout = 0;
  endtask

  // Advance the model by one clock using the inputs as they stand now.
  task automatic model_step();
    longint dci, dcq, xi, xq;
    bit bi, bq, free, consume, load;
    longint li, lq;
    dci = m_acc_i >>> AVG_SHIFT;
    dcq = m_acc_q >>> AVG_SHIFT;
    xi = longint'(i_in);
    xq = longint'(q_in);
    bi = decide(xi, dci, m_prev_i);
    bq = decide(xq, dcq, m_prev_q);
    if (in_strobe) begin
      m_prev_i = bi; m_prev_q = bq;
      m_acc_i += xi - dci;
      m_acc_q += xq - dcq;
    end
    free = !m_valid || out_ready;
    consume = m_valid && out_ready;
    load = 0; li = 0; lq = 0;
    if (!record) begin
      m_mode = 0;
      m_bits_i.delete(); m_bits_q.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (free) begin
        load = 1; li = MARK_WORD; lq = MARK_WORD; m_mode = 2;
        m_bits_i.delete(); m_bits_q.delete();
      end
    end else begin
      if (freq_step) begin
        m_mode = 1;
        m_bits_i.delete(); m_bits_q.delete();
      end else if (in_strobe) begin
        m_bits_i.push_back(bi); m_bits_q.push_back(bq);
        if (m_bits_i.size() == OUT_WIDTH) begin
          if (free) begin
            load = 1; li = pack_bits(m_bits_i); lq = pack_bits(m_bits_q);
          end else begin
            m_ov = 1;
          end
          m_bits_i.delete(); m_bits_q.delete();
        end
      end
    end
    if (load) begin
      m_valid = 1; m_iout = li; m_qout = lq;
    end else if (consume) begin
      m_valid = 0;
    end
  endtask

  // One clock: advance model at the edge, compare just after it.
  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check("out_valid", longint'(out_valid), longint'(m_valid));
    check("overflow", longint'(overflow), longint'(m_ov));
    check("i_dc", longint'(i_dc), m_acc_i >>> AVG_SHIFT);
    check("q_dc", longint'(q_dc), m_acc_q >>> AVG_SHIFT);
    if (m_valid) begin
      check("i_out", longint'(i_out), m_iout);
      check("q_out", longint'(q_out), m_qout);
    end
  endtask

  // Pulse reset off-edge and confirm outputs clear without a clock edge.
  task automatic async_reset(input int dly);
    #(dly);
    reset_n = 1'b0;
    #1;
    check("rst_valid", longint'(out_valid), 0);
    check("rst_i_dc", longint'(i_dc), 0);
    check("rst_q_dc", longint'(q_dc), 0);
    check("rst_overflow", longint'(overflow), 0);
    check("rst_i_out", longint'(i_out), 0);
    check("rst_q_out", longint'(q_out), 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    longint prev_dc;
    bit found;
    reset_n = 1'b1; in_strobe = 0; record = 0; freq_step = 0; out_ready = 0;
    i_in = '0; q_in = '0;
    model_reset();
    #1;
    async_reset(1);

    // Marker after reset with record high, held while out_ready is low.
    record = 1; out_ready = 0;
    for (int k = 0; k < 3; k++) step();
    check("marker_valid", longint'(out_valid), 1);
    check("marker_i", longint'(i_out), 64'h8000);
    check("marker_q", longint'(q_out), 64'h8000);

    // Constant +/-1000 input: first data word all ones / all zeros, DC rising.
    async_reset(3);
    record = 1; out_ready = 1; in_strobe = 1; i_in = 16'sd1000; q_in = -16'sd1000;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      step();
      if (out_valid && i_out != 16'h8000) found = 1;
    end
    check("first_word_seen", longint'(found), 1);
    check("first_word_i", longint'(i_out), 64'hFFFF);
    check("first_word_q", longint'(q_out), 64'h0000);
    prev_dc = longint'(i_dc);
    for (int k = 0; k < 400; k++) begin
      step();
      check("dc_monotonic", (longint'(i_dc) >= prev_dc) ? 1 : 0, 1);
      prev_dc = longint'(i_dc);
    end
    check("dc_moved", (longint'(i_dc) > 0 && longint'(i_dc) <= 1000) ? 1 : 0, 1);

    // Stall across two completions: hold first, drop second, sticky overflow.
    out_ready = 0;
    for (int k = 0; k < 40; k++) step();
    check("stall_overflow", longint'(overflow), 1);
    check("stall_valid", longint'(out_valid), 1);
    out_ready = 1;
    for (int k = 0; k < 10; k++) step();
    check("overflow_sticky", longint'(overflow), 1);

    // freq_step after 7 packed bits: partial word dropped, marker follows.
    async_reset(5);
    record = 1; out_ready = 1; in_strobe = 1;
    for (int k = 0; k < 9; k++) begin
      i_in = 16'($urandom); q_in = 16'($urandom);
      step();
    end
    freq_step = 1;
    step();
    freq_step = 0;
    step();
    check("fs_marker_valid", longint'(out_valid), 1);
    check("fs_marker_i", longint'(i_out), 64'h8000);
    for (int k = 0; k < 40; k++) begin
      i_in = 16'($urandom); q_in = 16'($urandom);
      step();
    end

`ifdef FSQ_HYSTERESIS_EN
    // Small toggling input inside the dead band: every data word constant.
    async_reset(2);
    record = 1; out_ready = 1; in_strobe = 1;
    for (int k = 0; k < 80; k++) begin
      i_in = (k % 2 == 0) ? 16'sd30 : -16'sd30;
      q_in = (k % 2 == 0) ? -16'sd30 : 16'sd30;
      step();
      if (out_valid && i_out != 16'h8000) check("hyst_word_i", longint'(i_out), 0);
    end
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      record    = ($urandom_range(0, 63) != 0);
      freq_step = ($urandom_range(0, 39) == 0);
      in_strobe = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (k % 700 < 350) begin
        i_in = 16'($urandom);
        q_in = 16'($urandom);
      end else begin
        i_in = 16'sd2000 + 16'($urandom_range(0, 400)) - 16'sd200;
        q_in = -16'sd1500 + 16'($urandom_range(0, 400)) - 16'sd200;
      end
      step();
      if (k % 600 == 599) async_reset(int'($urandom_range(1, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
